vxe_cu_cmd_dispatch: RTL and testbench
======================================

// Module: vxe_cu_cmd_dispatch
// PURPOSE
//  CU stage directly downstream of the CU fetch unit: pops 64-bit command words from the fetch FIFO and decodes them.
//  Holds CU setup registers (vector length, src/dst base addresses) and issues vector-op commands to the VPU dispatch port.
//  Handles SYNC/STOP/error; requests stop-and-drain from fetch on halt. Top-level FSM of the CU execution pipeline.
// PARAMETERS
//  VPU_CMD_W  = 128  width of packed VPU command {func[3:0],vlen[19:0],rd[36:0],rt[36:0],rs[29:0] lsbs}; fixed layout, do not change
//  ADDR_W     = 37   command word address width (64-bit word granularity)
// PORTS
//  clk             in   1    clock; one clock; reset is synchronous and active-high
//  rst             in   1    synchronous active-high reset
//  i_start         in   1    1-cycle pulse: begin execution (fetch unit started in same cycle)
//  o_busy          out  1    FSM not IDLE, or i_start high
//  i_fetch_vld     in   1    fetch FIFO head valid
//  i_fetch_addr    in   37   address of head command
//  i_fetch_data    in   64   head command word
//  i_fetch_err     in   1    head word carries bus error
//  o_fetch_rd      out  1    pop head (combinational)
//  o_stop_drain    out  1    1-cycle pulse: fetch unit stop and drain
//  o_vpu_cmd       out  128  VPU command, stable while o_vpu_vld && !i_vpu_rdy
//  o_vpu_vld       out  1    VPU command valid
//  i_vpu_rdy       in   1    VPU accepts command
//  i_vpu_busy      in   1    VPU has outstanding work
//  o_halt          out  1    1-cycle pulse: execution finished (STOP or error)
//  o_err           out  2    sticky: 01 fetch bus error, 10 bad opcode; cleared on i_start
//  o_err_addr      out  37   address of faulting command; cleared on i_start
// BEHAVIOUR
//  Opcode = data[63:59]. NOP 5'h00; SYNC 5'h01; SETVL 5'h08 (vlen=data[19:0]); SETRS 5'h0C, SETRT 5'h0D, SETRD 5'h0E
//  (reg=data[36:0]); RUN 5'h10 (func=data[3:0]); STOP 5'h1F. Others: bad opcode.
//  Reset: FSM IDLE; all outputs 0; vlen/rs/rt/rd=0.
//  FSM IDLE: on i_start -> DEC; clear o_err/o_err_addr; setup regs keep values.
//  DEC: o_fetch_rd = i_fetch_vld (every decoded word is popped in the cycle it is seen). If !i_fetch_vld, stay.
//   i_fetch_err: o_err|=01, o_err_addr=addr -> DRN. Error checked before opcode.
//   NOP/SETxx: register update next edge, stay DEC (1 command/cycle throughput).
//   RUN: latch o_vpu_cmd from current regs + func, o_vpu_vld=1 next cycle -> ISS.
//   SYNC -> SNC. STOP -> DRN. Bad opcode: o_err|=10, o_err_addr=addr -> DRN.
//  ISS: hold cmd; when o_vpu_vld && i_vpu_rdy: o_vpu_vld=0 -> DEC. No fetch pop in ISS.
//  SNC: -> DEC first cycle i_vpu_busy=0 (min 1 cycle in SNC).
//  DRN: entered with o_stop_drain pulsed on the entry edge; wait i_vpu_busy=0 and !o_vpu_vld, then
//   o_halt pulse -> IDLE. o_fetch_rd=0 in DRN (fetch drains itself).
//  Setup regs: SETVL vlen 20 bits, no check; vlen=0 RUN is issued unchanged (VPU treats as no-op).
//  i_start while not IDLE: ignored. rst mid-operation: immediate return to reset state, no o_halt, no o_stop_drain.
// CONFIGURATION
//  VXE_CU_PERFCNT_EN defined: adds ports o_cmd_cnt[31:0] (commands popped since i_start, includes faulting one)
//   and o_stall_cnt[31:0] (cycles in DEC with !i_fetch_vld, plus ISS with !i_vpu_rdy); both saturate at 32'hFFFFFFFF,
//   cleared on i_start and rst. Undefined: ports and counters absent, other behaviour identical.
// STRUCTURE
//  Shared header vxe_cu_defs.vh: opcode localparams, field bit positions, FSM state codes, o_err codes, VPU_CMD layout.
//  One sub-module vxe_cu_cmd_decoder: combinational opcode/field extraction + bad-opcode flag from i_fetch_data.
//  FSM, setup regs, VPU handshake, counters in this module.
// TESTING
//  SETVL 100, SETRS 0x100, SETRT 0x200, SETRD 0x300, RUN func 2, STOP (vpu_rdy=1) -> one VPU cmd vlen=100
//   rs/rt/rd as set func=2; o_stop_drain then o_halt pulse; 6 pops.
//  RUN with i_vpu_rdy low 5 cycles -> o_vpu_vld held, o_vpu_cmd stable, no o_fetch_rd until accept.
//  SYNC with i_vpu_busy high 10 cycles -> next word not popped until busy falls; popped the cycle after.
//  Word at addr 0x40 with i_fetch_err=1 -> o_err=01, o_err_addr=0x40, o_stop_drain, o_halt; new i_start clears o_err.
//  Opcode 5'h15 at addr 0x12 -> o_err=10, o_err_addr=0x12, halt; rst asserted mid-ISS -> all outputs 0 next cycle.
//  PERFCNT build: 4 NOPs with 3 empty cycles between -> o_cmd_cnt=4, o_stall_cnt=3.

Source files
------------

// File: rtl/vxe_cu_cmd_dispatch_pkg.sv
// rtl/vxe_cu_cmd_dispatch_pkg.sv - shared opcodes, field layout, FSM states and VPU command format for the CU dispatch stage
package vxe_cu_cmd_dispatch_pkg;

  localparam int ADDR_W    = 37;
  localparam int VPU_CMD_W = 128;
  localparam int VLEN_W    = 20;
  localparam int FUNC_W    = 4;
  localparam int RS_CMD_W  = 30;

  localparam int OP_MSB = 63;
  localparam int OP_LSB = 59;

  localparam logic [4:0] OP_NOP   = 5'h00;
  localparam logic [4:0] OP_SYNC  = 5'h01;
  localparam logic [4:0] OP_SETVL = 5'h08;
  localparam logic [4:0] OP_SETRS = 5'h0C;
  localparam logic [4:0] OP_SETRT = 5'h0D;
  localparam logic [4:0] OP_SETRD = 5'h0E;
  localparam logic [4:0] OP_RUN   = 5'h10;
  localparam logic [4:0] OP_STOP  = 5'h1F;

  localparam logic [1:0] ERR_FETCH  = 2'b01;
  localparam logic [1:0] ERR_OPCODE = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_DEC  = 3'd1,
    ST_ISS  = 3'd2,
    ST_SNC  = 3'd3,
    ST_DRN  = 3'd4
  } state_t;

  typedef enum logic [3:0] {
    K_NOP, K_SYNC, K_SETVL, K_SETRS, K_SETRT, K_SETRD, K_RUN, K_STOP, K_BAD
  } cmd_kind_t;

  // Fixed VPU command layout; rs keeps only its low 30 bits to fit 128.
  typedef struct packed {
    logic [FUNC_W-1:0]   func;
    logic [VLEN_W-1:0]   vlen;
    logic [ADDR_W-1:0]   rd;
    logic [ADDR_W-1:0]   rt;
    logic [RS_CMD_W-1:0] rs;
  } vpu_cmd_t;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/vxe_cu_cmd_dispatch_if.sv
// rtl/vxe_cu_cmd_dispatch_if.sv - fetch FIFO head and VPU dispatch handshake bundle of the CU dispatch stage
interface vxe_cu_cmd_dispatch_if;
  import vxe_cu_cmd_dispatch_pkg::*;

  logic                 i_fetch_vld;
  logic [ADDR_W-1:0]    i_fetch_addr;
  logic [63:0]          i_fetch_data;
  logic                 i_fetch_err;
  logic                 o_fetch_rd;
  logic                 o_stop_drain;
  logic [VPU_CMD_W-1:0] o_vpu_cmd;
  logic                 o_vpu_vld;
  logic                 i_vpu_rdy;
  logic                 i_vpu_busy;

  modport master (
    input  i_fetch_vld, i_fetch_addr, i_fetch_data, i_fetch_err,
    output o_fetch_rd, o_stop_drain,
    output o_vpu_cmd, o_vpu_vld,
    input  i_vpu_rdy, i_vpu_busy
  );

  modport slave (
    output i_fetch_vld, i_fetch_addr, i_fetch_data, i_fetch_err,
    input  o_fetch_rd, o_stop_drain,
    input  o_vpu_cmd, o_vpu_vld,
    output i_vpu_rdy, i_vpu_busy
  );

endinterface

// File: rtl/vxe_cu_cmd_decoder.sv
// rtl/vxe_cu_cmd_decoder.sv - combinational opcode classification and field extraction of a 64-bit CU command word
module vxe_cu_cmd_decoder
  import vxe_cu_cmd_dispatch_pkg::*;
(
  input  logic [63:0]       data,
  output cmd_kind_t         kind,
  output logic [VLEN_W-1:0] vlen,
  output logic [ADDR_W-1:0] reg_val,
  output logic [FUNC_W-1:0] func,
  output logic              bad_op
);

  logic [4:0] opcode;
  logic       unused_mid_bits;

  assign opcode  = data[OP_MSB:OP_LSB];
  assign vlen    = data[VLEN_W-1:0];
  assign reg_val = data[ADDR_W-1:0];
  assign func    = data[FUNC_W-1:0];
  assign bad_op  = (kind == K_BAD);

  // Bits between the address field and the opcode carry no meaning for any command.
  assign unused_mid_bits = ^data[OP_LSB-1:ADDR_W];

  always_comb begin
    kind = K_BAD;
    case (opcode)
      OP_NOP:   kind = K_NOP;
      OP_SYNC:  kind = K_SYNC;
      OP_SETVL: kind = K_SETVL;
      OP_SETRS: kind = K_SETRS;
      OP_SETRT: kind = K_SETRT;
      OP_SETRD: kind = K_SETRD;
      OP_RUN:   kind = K_RUN;
      OP_STOP:  kind = K_STOP;
      default:  kind = K_BAD;
    endcase
  end

endmodule

// File: rtl/vxe_cu_cmd_dispatch.sv
// rtl/vxe_cu_cmd_dispatch.sv - CU command decode/dispatch FSM; VXE_CU_PERFCNT_EN adds command and stall counters
module vxe_cu_cmd_dispatch
  import vxe_cu_cmd_dispatch_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_start,
  output logic                   o_busy,
  vxe_cu_cmd_dispatch_if.master  bus,
  output logic                   o_halt,
  output logic [1:0]             o_err,
  output logic [ADDR_W-1:0]      o_err_addr
`ifdef VXE_CU_PERFCNT_EN
  ,
  output logic [31:0]            o_cmd_cnt,
  output logic [31:0]            o_stall_cnt
`endif
);

  state_t            state;
  logic [VLEN_W-1:0] vlen_q;
  logic [ADDR_W-1:0] rs_q;
  logic [ADDR_W-1:0] rt_q;
  logic [ADDR_W-1:0] rd_q;
  vpu_cmd_t          cmd_q;
  logic              vpu_vld_q;
  logic              stop_drain_q;
  logic              halt_q;
  logic              fetch_rd;

  cmd_kind_t         dec_kind;
  logic [VLEN_W-1:0] dec_vlen;
  logic [ADDR_W-1:0] dec_reg;
  logic [FUNC_W-1:0] dec_func;
  logic              dec_bad;
  logic              unused_rs_hi;

  vxe_cu_cmd_decoder u_decoder (
    .data    (bus.i_fetch_data),
    .kind    (dec_kind),
    .vlen    (dec_vlen),
    .reg_val (dec_reg),
    .func    (dec_func),
    .bad_op  (dec_bad)
  );

  assign fetch_rd         = (state == ST_DEC) && bus.i_fetch_vld;
  assign bus.o_fetch_rd   = fetch_rd;
  assign bus.o_stop_drain = stop_drain_q;
  assign bus.o_vpu_cmd    = cmd_q;
  assign bus.o_vpu_vld    = vpu_vld_q;
  assign o_busy           = (state != ST_IDLE) || i_start;
  assign o_halt           = halt_q;
  // Only the low 30 bits of rs travel in the VPU command.
  assign unused_rs_hi     = ^rs_q[ADDR_W-1:RS_CMD_W];

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ST_IDLE;
      vlen_q       <= '0;
      rs_q         <= '0;
      rt_q         <= '0;
      rd_q         <= '0;
      cmd_q        <= '0;
      vpu_vld_q    <= 1'b0;
      stop_drain_q <= 1'b0;
      halt_q       <= 1'b0;
      o_err        <= '0;
      o_err_addr   <= '0;
    end else begin
      stop_drain_q <= 1'b0;
      halt_q       <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (i_start) begin
            state      <= ST_DEC;
            o_err      <= '0;
            o_err_addr <= '0;
          end
        end
        ST_DEC: begin
          // A bus error wins over whatever opcode the corrupted word appears to hold.
          if (bus.i_fetch_vld) begin
            if (bus.i_fetch_err) begin
              o_err        <= o_err | ERR_FETCH;
              o_err_addr   <= bus.i_fetch_addr;
              stop_drain_q <= 1'b1;
              state        <= ST_DRN;
            end else if (dec_bad) begin
              o_err        <= o_err | ERR_OPCODE;
              o_err_addr   <= bus.i_fetch_addr;
              stop_drain_q <= 1'b1;
              state        <= ST_DRN;
            end else begin
              case (dec_kind)
                K_SETVL: vlen_q <= dec_vlen;
                K_SETRS: rs_q   <= dec_reg;
                K_SETRT: rt_q   <= dec_reg;
                K_SETRD: rd_q   <= dec_reg;
                K_RUN: begin
                  cmd_q     <= '{func: dec_func, vlen: vlen_q, rd: rd_q, rt: rt_q,
                                 rs: rs_q[RS_CMD_W-1:0]};
                  vpu_vld_q <= 1'b1;
                  state     <= ST_ISS;
                end
                K_SYNC: state <= ST_SNC;
                K_STOP: begin
                  stop_drain_q <= 1'b1;
                  state        <= ST_DRN;
                end
                default: ;
              endcase
            end
          end
        end
        ST_ISS: begin
          if (vpu_vld_q && bus.i_vpu_rdy) begin
            vpu_vld_q <= 1'b0;
            state     <= ST_DEC;
          end
        end
        ST_SNC: begin
          if (!bus.i_vpu_busy) state <= ST_DEC;
        end
        ST_DRN: begin
          if (!bus.i_vpu_busy && !vpu_vld_q) begin
            halt_q <= 1'b1;
            state  <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef VXE_CU_PERFCNT_EN
  logic [31:0] cmd_cnt_q;
  logic [31:0] stall_cnt_q;
  logic        stall;

  assign stall       = ((state == ST_DEC) && !bus.i_fetch_vld) ||
                       ((state == ST_ISS) && !bus.i_vpu_rdy);
  assign o_cmd_cnt   = cmd_cnt_q;
  assign o_stall_cnt = stall_cnt_q;

  always_ff @(posedge clk) begin
    if (rst || ((state == ST_IDLE) && i_start)) begin
      cmd_cnt_q   <= '0;
      stall_cnt_q <= '0;
    end else begin
      if (fetch_rd) cmd_cnt_q   <= sat_inc(cmd_cnt_q);
      if (stall)    stall_cnt_q <= sat_inc(stall_cnt_q);
    end
  end
`endif

endmodule

// File: tb/tb_vxe_cu_cmd_dispatch.sv
// tb/tb_vxe_cu_cmd_dispatch.sv - self-checking bench for the CU command dispatch stage
module tb_vxe_cu_cmd_dispatch;

  localparam logic [4:0] T_NOP = 5'h00, T_SYNC = 5'h01, T_SETVL = 5'h08, T_SETRS = 5'h0C,
                         T_SETRT = 5'h0D, T_SETRD = 5'h0E, T_RUN = 5'h10, T_STOP = 5'h1F;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_start;
  logic        o_busy;
  logic        o_halt;
  logic [1:0]  o_err;
  logic [36:0] o_err_addr;
`ifdef VXE_CU_PERFCNT_EN
  logic [31:0] o_cmd_cnt;
  logic [31:0] o_stall_cnt;
`endif

  vxe_cu_cmd_dispatch_if bus ();

  vxe_cu_cmd_dispatch dut (
    .clk        (clk),
    .rst        (rst),
    .i_start    (i_start),
    .o_busy     (o_busy),
    .bus        (bus),
    .o_halt     (o_halt),
    .o_err      (o_err),
    .o_err_addr (o_err_addr)
`ifdef VXE_CU_PERFCNT_EN
    ,
    .o_cmd_cnt  (o_cmd_cnt),
    .o_stall_cnt(o_stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [36:0] addr;
    logic [63:0] data;
    logic        err;
    int          gap;
  } word_t;

  typedef struct {
    int          cyc;
    logic [63:0] data;
  } pop_t;

  typedef struct {
    logic [4:0]  op;
    logic [36:0] addr;
    logic        ferr;
    logic [1:0]  exp_err;
    logic [36:0] exp_addr;
  } vec_t;

  word_t        prog[$];
  logic [127:0] sb[$];
  pop_t         pop_log[$];
  vec_t         vecs[6];

  int total = 0, bad = 0;
  int cyc = 0, pops = 0, halts = 0, drains = 0, fires = 0, hold_cycles = 0;
  int halt_cyc = 0, drain_cyc = 0;
  int vpu_wait = 0, rdy_delay = 0, gap_left = 0;
  bit fetch_fire = 1'b0, prev_hold = 1'b0;
  logic [127:0] prev_cmd = '0;

  logic [19:0] m_vlen = '0;
  logic [36:0] m_rs = '0, m_rt = '0, m_rd = '0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  // Queue a command word; the reference register model and VPU scoreboard follow it.
  task automatic add(input logic [4:0] op, input logic [63:0] payload, input logic [36:0] addr,
                     input logic err, input int gap);
    word_t w;
    w.addr = addr;
    w.data = {op, payload[58:0]};
    w.err  = err;
    w.gap  = gap;
    prog.push_back(w);
    if (!err) begin
      case (op)
        T_SETVL: m_vlen = payload[19:0];
        T_SETRS: m_rs   = payload[36:0];
        T_SETRT: m_rt   = payload[36:0];
        T_SETRD: m_rd   = payload[36:0];
        T_RUN:   sb.push_back({payload[3:0], m_vlen, m_rd, m_rt, m_rs[29:0]});
        default: ;
      endcase
    end
  endtask

  task automatic start_prog();
    gap_left = (prog.size() > 0) ? prog[0].gap : 0;
    pops = 0; halts = 0; drains = 0; fires = 0; hold_cycles = 0;
    pop_log.delete();
    step();
    i_start = 1'b1;
    #1;
    check("busy_on_start", o_busy, 1);
    step();
    i_start = 1'b0;
  endtask

  task automatic wait_halt(input string name);
    int n;
    n = 0;
    while (halts == 0 && n < 3000) begin
      step();
      n++;
    end
    if (halts == 0) begin
      total++; bad++;
      $display("FAIL %s halt_timeout actual=none required=halt", name);
    end
    step();
    step();
  endtask

  // Fetch FIFO and VPU ready models, updated just after each rising edge.
  always @(posedge clk) begin
    cyc++;
    if (fetch_fire && prog.size() > 0) begin
      void'(prog.pop_front());
      gap_left = (prog.size() > 0) ? prog[0].gap : 0;
    end else if (!bus.i_fetch_vld && gap_left > 0) begin
      gap_left--;
    end
    #1;
    bus.i_fetch_vld  = (prog.size() > 0) && (gap_left == 0);
    bus.i_fetch_addr = (prog.size() > 0) ? prog[0].addr : '0;
    bus.i_fetch_data = (prog.size() > 0) ? prog[0].data : '0;
    bus.i_fetch_err  = (prog.size() > 0) ? prog[0].err : 1'b0;
    bus.i_vpu_rdy    = (vpu_wait >= rdy_delay);
  end

  always @(negedge clk) begin
    fetch_fire = bus.o_fetch_rd && bus.i_fetch_vld;
    if (bus.o_fetch_rd) check("fetch_rd_without_vld", bus.i_fetch_vld, 1);
    if (fetch_fire) begin
      pops++;
      pop_log.push_back('{cyc: cyc, data: bus.i_fetch_data});
    end
    if (bus.o_vpu_vld && bus.i_vpu_rdy) begin
      fires++;
      if (sb.size() == 0) begin
        total++; bad++;
        $display("FAIL vpu_cmd unexpected actual=%0h required=none", bus.o_vpu_cmd);
      end else begin
        check("vpu_cmd", bus.o_vpu_cmd, sb.pop_front());
      end
    end
    if (bus.o_vpu_vld && !bus.i_vpu_rdy) begin
      hold_cycles++;
      vpu_wait++;
      check("pop_during_iss", bus.o_fetch_rd, 0);
      if (prev_hold) check("vpu_cmd_stable", bus.o_vpu_cmd, prev_cmd);
    end else begin
      vpu_wait = 0;
    end
    prev_hold = bus.o_vpu_vld && !bus.i_vpu_rdy;
    prev_cmd  = bus.o_vpu_cmd;
    if (o_halt) begin halts++; halt_cyc = cyc; end
    if (bus.o_stop_drain) begin drains++; drain_cyc = cyc; end
  end

  initial begin
    int n, k;
    vecs[0] = '{op: T_NOP,  addr: 37'h40,         ferr: 1'b1, exp_err: 2'b01, exp_addr: 37'h40};
    vecs[1] = '{op: T_STOP, addr: 37'h05,         ferr: 1'b0, exp_err: 2'b00, exp_addr: 37'h0};
    vecs[2] = '{op: 5'h15,  addr: 37'h12,         ferr: 1'b0, exp_err: 2'b10, exp_addr: 37'h12};
    vecs[3] = '{op: T_STOP, addr: 37'h33,         ferr: 1'b1, exp_err: 2'b01, exp_addr: 37'h33};
    vecs[4] = '{op: 5'h02,  addr: 37'h07,         ferr: 1'b0, exp_err: 2'b10, exp_addr: 37'h07};
    vecs[5] = '{op: 5'h1E,  addr: 37'h1F_FFFF_FFFF, ferr: 1'b0, exp_err: 2'b10, exp_addr: 37'h1F_FFFF_FFFF};

    rst = 1'b1;
    i_start = 1'b0;
    bus.i_fetch_vld = 1'b0; bus.i_fetch_addr = '0; bus.i_fetch_data = '0;
    bus.i_fetch_err = 1'b0; bus.i_vpu_rdy = 1'b1; bus.i_vpu_busy = 1'b0;
    repeat (3) step();
    check("rst_busy", o_busy, 0);
    check("rst_fetch_rd", bus.o_fetch_rd, 0);
    check("rst_stop_drain", bus.o_stop_drain, 0);
    check("rst_vpu_vld", bus.o_vpu_vld, 0);
    check("rst_vpu_cmd", bus.o_vpu_cmd, 0);
    check("rst_halt", o_halt, 0);
    check("rst_err", o_err, 0);
    check("rst_err_addr", o_err_addr, 0);
    rst = 1'b0;
    step();

    // Full setup then one RUN and STOP with an always-ready VPU.
    add(T_SETVL, 64'd100,   37'h0, 1'b0, 0);
    add(T_SETRS, 64'h100,   37'h1, 1'b0, 0);
    add(T_SETRT, 64'h200,   37'h2, 1'b0, 0);
    add(T_SETRD, 64'h300,   37'h3, 1'b0, 0);
    add(T_RUN,   64'h2,     37'h4, 1'b0, 0);
    add(T_STOP,  64'h0,     37'h5, 1'b0, 0);
    start_prog();
    wait_halt("basic");
    check("basic_pops", pops, 6);
    check("basic_vpu_fires", fires, 1);
    check("basic_drains", drains, 1);
    check("basic_halts", halts, 1);
    check("basic_drain_before_halt", (drain_cyc < halt_cyc), 1);
    check("basic_err", o_err, 0);
    check("basic_sb_empty", sb.size(), 0);

    // VPU back-pressure for five cycles; junk above the vlen field must be ignored.
    rdy_delay = 5;
    add(T_SETVL, 64'h0000_0004_0010_0007, 37'h10, 1'b0, 0);
    add(T_RUN,   64'h5, 37'h11, 1'b0, 0);
    add(T_NOP,   64'h0, 37'h12, 1'b0, 0);
    add(T_STOP,  64'h0, 37'h13, 1'b0, 0);
    start_prog();
    wait_halt("backpressure");
    check("bp_hold_cycles", hold_cycles, 5);
    check("bp_pops", pops, 4);
    check("bp_sb_empty", sb.size(), 0);
    rdy_delay = 0;

    // SYNC waits for the VPU to go idle, then the next word is popped one cycle later.
    bus.i_vpu_busy = 1'b1;
    add(T_SYNC, 64'h0, 37'h200, 1'b0, 0);
    add(T_NOP,  64'h0, 37'h201, 1'b0, 0);
    add(T_STOP, 64'h0, 37'h202, 1'b0, 0);
    start_prog();
    n = 0;
    while (pops == 0 && n < 50) begin step(); n++; end
    check("sync_popped", pops, 1);
    repeat (10) step();
    check("sync_no_pop_while_busy", pops, 1);
    bus.i_vpu_busy = 1'b0;
    k = cyc;
    wait_halt("sync");
    check("sync_pops", pops, 3);
    if (pop_log.size() >= 2) check("sync_next_pop_cycle", pop_log[1].cyc, k + 1);
    else check("sync_next_pop_present", pop_log.size(), 2);

    // Error/termination table: one SETVL then the word under test.
    for (int i = 0; i < 6; i++) begin
      add(T_SETVL, 64'd3, 37'h1, 1'b0, 0);
      add(vecs[i].op, 64'h0, vecs[i].addr, vecs[i].ferr, 0);
      start_prog();
      wait_halt($sformatf("vec%0d", i));
      check($sformatf("vec%0d_err", i), o_err, vecs[i].exp_err);
      check($sformatf("vec%0d_err_addr", i), o_err_addr, vecs[i].exp_addr);
      check($sformatf("vec%0d_pops", i), pops, 2);
      check($sformatf("vec%0d_drains", i), drains, 1);
      check($sformatf("vec%0d_halts", i), halts, 1);
    end

    // A fresh start clears the sticky error left by the last vector.
    add(T_STOP, 64'h0, 37'h9, 1'b0, 0);
    start_prog();
    check("start_clears_err", o_err, 0);
    check("start_clears_err_addr", o_err_addr, 0);
    wait_halt("clear");

    // Reset while a command waits in ISS; a stray start there must be ignored.
    rdy_delay = 1000;
    add(T_RUN,  64'h9, 37'h30, 1'b0, 0);
    add(T_STOP, 64'h0, 37'h31, 1'b0, 0);
    start_prog();
    n = 0;
    while (!bus.o_vpu_vld && n < 50) begin step(); n++; end
    check("iss_vld", bus.o_vpu_vld, 1);
    i_start = 1'b1;
    step();
    i_start = 1'b0;
    check("start_ignored_vld", bus.o_vpu_vld, 1);
    check("start_ignored_pops", pops, 1);
    rst = 1'b1;
    step();
    check("midrst_busy", o_busy, 0);
    check("midrst_fetch_rd", bus.o_fetch_rd, 0);
    check("midrst_vpu_vld", bus.o_vpu_vld, 0);
    check("midrst_vpu_cmd", bus.o_vpu_cmd, 0);
    check("midrst_stop_drain", bus.o_stop_drain, 0);
    check("midrst_halt", o_halt, 0);
    check("midrst_err", o_err, 0);
    rst = 1'b0;
    prog.delete();
    sb.delete();
    m_vlen = '0; m_rs = '0; m_rt = '0; m_rd = '0;
    rdy_delay = 0;
    step();
    step();
    check("midrst_no_halt", halts, 0);
    check("midrst_no_drain", drains, 0);

`ifdef VXE_CU_PERFCNT_EN
    add(T_NOP,  64'h0, 37'h50, 1'b0, 0);
    add(T_NOP,  64'h0, 37'h51, 1'b0, 1);
    add(T_NOP,  64'h0, 37'h52, 1'b0, 1);
    add(T_NOP,  64'h0, 37'h53, 1'b0, 1);
    add(T_STOP, 64'h0, 37'h54, 1'b0, 0);
    start_prog();
    wait_halt("perf");
    check("perf_cmd_cnt", o_cmd_cnt, 5);
    check("perf_stall_cnt", o_stall_cnt, 3);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
